apb_video_ctrl_regs: RTL and testbench



---
 rtl/video_ctrl_pkg.sv | 18 +
 rtl/vsync_edge_sync.sv | 18 +
 rtl/apb_video_ctrl_regs.sv | 138 +++++++++++++
 tb/tb_apb_video_ctrl_regs.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_ctrl_pkg.sv
// Shared register map, control/status bit positions and display-mode encodings
// for the video pipeline control block.
package video_ctrl_pkg;
   localparam int OFF_CTRL      = 'h000;
   localparam int OFF_STATUS    = 'h004;
   localparam int OFF_IRQ_EN    = 'h008;
   localparam int OFF_FRAME_CNT = 'h00C;
   localparam int CH_BASE       = 'h010;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_SYNC = 1;
   localparam int STAT_DONE = 0;
   localparam int STAT_PEND = 1;

   localparam int MODE_RAW  = 0;
   localparam int MODE_GREY = 1;
   localparam int MODE_BIN  = 2;
endpackage

// File: rtl/vsync_edge_sync.sv
// Brings camera vsync into the PCLK domain and emits a one-cycle pulse on its
// rising edge; the pulse is seen by logic clocked on the third edge after vsync rises.
module vsync_edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic pulse_o
);
   // [0],[1] form the synchroniser; [2] remembers the previous synchronised level
   logic [2:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[1:0], async_i};
   end

   assign pulse_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/apb_video_ctrl_regs.sv
// APB3 control/status slave: double-buffered per-channel threshold/mode registers,
// frame counter, sticky frame-done flag with level interrupt.
module apb_video_ctrl_regs
   import video_ctrl_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int THR_W   = 8,
   parameter int MODE_W  = 2,
   parameter int THR_RST = 68,
   parameter int ADDR_W  = 12
) (
   input  logic                       PCLK,
   input  logic                       PRESETN,
   input  logic                       PSEL,
   input  logic [ADDR_W-3:0]          PADDR,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [31:0]                PWDATA,
   output logic [31:0]                PRDATA,
   output logic                       PREADY,
   output logic                       PSLVERR,
   input  logic                       vsync_async,
   output logic [NUM_CH*THR_W-1:0]    threshold_o,
   output logic [NUM_CH*MODE_W-1:0]   mode_o,
   output logic                       irq
);
   localparam logic [ADDR_W-1:0] END_OFF = ADDR_W'(CH_BASE + 4*NUM_CH);

   logic [NUM_CH-1:0][THR_W-1:0]  sh_thr_q, act_thr_q;
   logic [NUM_CH-1:0][MODE_W-1:0] sh_mode_q, act_mode_q;
   logic [1:0]        ctrl_q;
   logic              irq_en_q, done_q, pend_q, irq_q, slverr_q;
   logic [31:0]       cnt_q, prdata_q, rd_d;
   logic [ADDR_W-1:0] off;
   logic              addr_err, setup, wr, wr_ctrl, wr_stat, wr_ien;
   logic              frame_start, frame_ev, commit;
   logic [NUM_CH-1:0] ch_wr;
   logic              unused_pwdata;

   vsync_edge_sync u_vsync (
      .clk_i   (PCLK),
      .rst_ni  (PRESETN),
      .async_i (vsync_async),
      .pulse_o (frame_start)
   );

   assign off      = {PADDR, 2'b00};
   assign addr_err = (off >= END_OFF);
   assign setup    = PSEL & ~PENABLE;
   assign wr       = PSEL & PENABLE & PWRITE & ~addr_err;
   assign wr_ctrl  = wr & (off == ADDR_W'(OFF_CTRL));
   assign wr_stat  = wr & (off == ADDR_W'(OFF_STATUS));
   assign wr_ien   = wr & (off == ADDR_W'(OFF_IRQ_EN));
   assign frame_ev = frame_start & ctrl_q[CTRL_EN];
   // Commit copies the shadow as it was before this edge's write; dropping
   // sync_commit flushes anything still pending.
   assign commit   = pend_q & (frame_start |
                     (wr_ctrl & ctrl_q[CTRL_SYNC] & ~PWDATA[CTRL_SYNC]));
   assign unused_pwdata = ^PWDATA;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ch_wr[g] = wr & (off == ADDR_W'(CH_BASE + 4*g));

      always_ff @(posedge PCLK) begin
         if (!PRESETN) begin
            sh_thr_q[g]   <= THR_W'(THR_RST);
            act_thr_q[g]  <= THR_W'(THR_RST);
            sh_mode_q[g]  <= '0;
            act_mode_q[g] <= '0;
         end else begin
            if (commit) begin
               act_thr_q[g]  <= sh_thr_q[g];
               act_mode_q[g] <= sh_mode_q[g];
            end
            if (ch_wr[g]) begin
               sh_thr_q[g]  <= PWDATA[THR_W-1:0];
               sh_mode_q[g] <= PWDATA[16 +: MODE_W];
               if (!ctrl_q[CTRL_SYNC]) begin
                  act_thr_q[g]  <= PWDATA[THR_W-1:0];
                  act_mode_q[g] <= PWDATA[16 +: MODE_W];
               end
            end
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         ctrl_q   <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl_q   <= PWDATA[1:0];
         if (wr_ien)  irq_en_q <= PWDATA[0];
         if (|ch_wr && ctrl_q[CTRL_SYNC]) pend_q <= 1'b1;
         else if (commit)                 pend_q <= 1'b0;
         if (frame_ev) cnt_q <= cnt_q + 32'd1;
         // a frame event in the same cycle as a W1C keeps the flag set
         if (frame_ev)                          done_q <= 1'b1;
         else if (wr_stat && PWDATA[STAT_DONE]) done_q <= 1'b0;
         irq_q <= done_q & irq_en_q;
      end
   end

   always_comb begin
      rd_d = '0;
      if (off == ADDR_W'(OFF_CTRL))           rd_d[1:0] = ctrl_q;
      else if (off == ADDR_W'(OFF_STATUS))    rd_d[STAT_PEND:STAT_DONE] = {pend_q, done_q};
      else if (off == ADDR_W'(OFF_IRQ_EN))    rd_d[0] = irq_en_q;
      else if (off == ADDR_W'(OFF_FRAME_CNT)) rd_d = cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (off == ADDR_W'(CH_BASE + 4*i)) begin
            rd_d[THR_W-1:0]    = sh_thr_q[i];
            rd_d[16 +: MODE_W] = sh_mode_q[i];
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         prdata_q <= '0;
         slverr_q <= 1'b0;
      end else if (setup) begin
         slverr_q <= addr_err;
         if (!PWRITE) prdata_q <= addr_err ? 32'd0 : rd_d;
      end
   end

   assign PRDATA      = prdata_q;
   assign PSLVERR     = slverr_q;
   assign PREADY      = 1'b1;
   assign irq         = irq_q;
   assign threshold_o = act_thr_q;
   assign mode_o      = act_mode_q;
endmodule

// File: tb/tb_apb_video_ctrl_regs.sv
// Randomised APB/vsync stimulus against a per-edge register-map model, plus
// directed scenarios for commit timing, W1C races, errors and reset.
module tb_apb_video_ctrl_regs;
   localparam int NUM_CH = 2, THR_W = 8, MODE_W = 2, THR_RST = 68, ADDR_W = 12;

   logic PCLK = 1'b0;
   logic PRESETN, PSEL, PENABLE, PWRITE, vsync_async;
   logic [ADDR_W-3:0] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic PREADY, PSLVERR, irq;
   logic [NUM_CH*THR_W-1:0]  threshold_o;
   logic [NUM_CH*MODE_W-1:0] mode_o;

   apb_video_ctrl_regs #(.NUM_CH(NUM_CH), .THR_W(THR_W), .MODE_W(MODE_W),
                         .THR_RST(THR_RST), .ADDR_W(ADDR_W)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .vsync_async(vsync_async), .threshold_o(threshold_o),
      .mode_o(mode_o), .irq(irq));

   always #5 PCLK = ~PCLK;

   int n_tot = 0, n_bad = 0;

   // reference state
   logic [THR_W-1:0]  m_sh_thr[NUM_CH], m_act_thr[NUM_CH];
   logic [MODE_W-1:0] m_sh_mode[NUM_CH], m_act_mode[NUM_CH];
   logic [1:0]  m_ctrl;
   logic        m_ien, m_done, m_pend, m_irq, m_err;
   logic [31:0] m_cnt, m_prd;
   logic        h1, h2, h3;   // vsync as sampled 1, 2, 3 edges ago
   bit          rand_vs = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mread(input int boff);
      logic [31:0] r;
      r = '0;
      if (boff == 0) r[1:0] = m_ctrl;
      else if (boff == 4) r[1:0] = {m_pend, m_done};
      else if (boff == 8) r[0] = m_ien;
      else if (boff == 12) r = m_cnt;
      else if (boff >= 16 && boff < 16 + 4*NUM_CH) begin
         r[THR_W-1:0]    = m_sh_thr[(boff-16)/4];
         r[16 +: MODE_W] = m_sh_mode[(boff-16)/4];
      end
      return r;
   endfunction

   task automatic step();
      logic [THR_W-1:0]  n_sh_thr[NUM_CH], n_act_thr[NUM_CH];
      logic [MODE_W-1:0] n_sh_mode[NUM_CH], n_act_mode[NUM_CH];
      logic [1:0]  n_ctrl;
      logic        n_ien, n_done, n_pend, n_irq, n_err, fs, ev, err;
      logic [31:0] n_cnt, n_prd;
      logic [NUM_CH*THR_W-1:0]  et;
      logic [NUM_CH*MODE_W-1:0] em;
      int boff, ch;
      n_sh_thr = m_sh_thr; n_act_thr = m_act_thr;
      n_sh_mode = m_sh_mode; n_act_mode = m_act_mode;
      n_ctrl = m_ctrl; n_ien = m_ien; n_done = m_done; n_pend = m_pend;
      n_cnt = m_cnt; n_prd = m_prd; n_err = m_err;
      n_irq = m_done & m_ien;
      boff = int'({PADDR, 2'b00});
      err  = (boff >= 16 + 4*NUM_CH);
      fs   = h2 & ~h3;
      ev   = fs & m_ctrl[0];
      if (fs && m_pend) begin
         n_act_thr = m_sh_thr; n_act_mode = m_sh_mode; n_pend = 1'b0;
      end
      if (ev) begin n_cnt = m_cnt + 1; n_done = 1'b1; end
      if (PSEL && PENABLE && PWRITE && !err) begin
         if (boff == 0) begin
            if (m_ctrl[1] && !PWDATA[1] && m_pend) begin
               n_act_thr = m_sh_thr; n_act_mode = m_sh_mode; n_pend = 1'b0;
            end
            n_ctrl = PWDATA[1:0];
         end else if (boff == 4) begin
            if (PWDATA[0] && !ev) n_done = 1'b0;
         end else if (boff == 8) begin
            n_ien = PWDATA[0];
         end else if (boff >= 16) begin
            ch = (boff - 16) / 4;
            n_sh_thr[ch]  = PWDATA[THR_W-1:0];
            n_sh_mode[ch] = PWDATA[16 +: MODE_W];
            if (m_ctrl[1]) n_pend = 1'b1;
            else begin
               n_act_thr[ch]  = PWDATA[THR_W-1:0];
               n_act_mode[ch] = PWDATA[16 +: MODE_W];
            end
         end
      end
      if (PSEL && !PENABLE) begin
         n_err = err;
         if (!PWRITE) n_prd = err ? 32'd0 : mread(boff);
      end
      if (!PRESETN) begin
         for (int i = 0; i < NUM_CH; i++) begin
            n_sh_thr[i] = THR_W'(THR_RST); n_act_thr[i] = THR_W'(THR_RST);
            n_sh_mode[i] = '0; n_act_mode[i] = '0;
         end
         n_ctrl = '0; n_ien = 0; n_done = 0; n_pend = 0; n_irq = 0;
         n_cnt = '0; n_prd = '0; n_err = 0;
         h1 = 0; h2 = 0; h3 = 0;
      end else begin
         h3 = h2; h2 = h1; h1 = vsync_async;
      end
      @(posedge PCLK);
      m_sh_thr = n_sh_thr; m_act_thr = n_act_thr;
      m_sh_mode = n_sh_mode; m_act_mode = n_act_mode;
      m_ctrl = n_ctrl; m_ien = n_ien; m_done = n_done; m_pend = n_pend;
      m_irq = n_irq; m_cnt = n_cnt; m_prd = n_prd; m_err = n_err;
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         et[i*THR_W +: THR_W]   = m_act_thr[i];
         em[i*MODE_W +: MODE_W] = m_act_mode[i];
      end
      chk("threshold_o", threshold_o, et);
      chk("mode_o", mode_o, em);
      chk("irq", irq, m_irq);
      chk("PSLVERR", PSLVERR, m_err);
      chk("PRDATA", PRDATA, m_prd);
      if (rand_vs && $urandom_range(0, 5) == 0) vsync_async = ~vsync_async;
   endtask

   task automatic apb(input bit wr, input int boff, input logic [31:0] d,
                      output logic [31:0] rd, output logic err);
      PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = (ADDR_W-2)'(boff >> 2); PWDATA = d;
      step();
      rd = PRDATA; err = PSLVERR;
      PENABLE = 1;
      step();
      PSEL = 0; PENABLE = 0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   logic [31:0] rd;
   logic err;

   initial begin
      PRESETN = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      vsync_async = 0;
      h1 = 0; h2 = 0; h3 = 0;
      steps(2);
      PRESETN = 1;
      step();

      // reset state
      apb(0, 'h10, 0, rd, err); chk("rst_ch0", rd, 32'h44); chk("rst_err", err, 0);
      apb(0, 'h14, 0, rd, err); chk("rst_ch1", rd, 32'h44);
      chk("rst_thr", threshold_o, 16'h4444); chk("rst_mode", mode_o, 4'h0);
      chk("PREADY", PREADY, 1'b1);

      // immediate commit
      apb(1, 'h14, 32'h0002_0080, rd, err);
      chk("imm_thr", threshold_o[15:8], 8'h80); chk("imm_mode", mode_o[3:2], 2'd2);
      apb(0, 'h14, 0, rd, err); chk("imm_rb", rd, 32'h0002_0080);

      // frame-synchronous commit
      apb(1, 'h08, 1, rd, err);
      apb(1, 'h00, 3, rd, err);
      apb(1, 'h10, 32'h0001_0030, rd, err);
      chk("sync_hold", threshold_o[7:0], 8'h44);
      apb(0, 'h04, 0, rd, err); chk("sync_pend", rd, 32'h2);
      vsync_async = 1;
      steps(3);
      chk("sync_thr", threshold_o[7:0], 8'h30); chk("sync_mode", mode_o[1:0], 2'd1);
      chk("irq_lat", irq, 0);
      step(); chk("irq_rise", irq, 1);
      apb(0, 'h04, 0, rd, err); chk("stat_done", rd, 32'h1);
      apb(0, 'h0C, 0, rd, err); chk("fcnt1", rd, 32'd1);

      // CH_CFG write landing on the frame_start edge
      apb(1, 'h10, 32'h0002_0055, rd, err);
      vsync_async = 0; steps(3);
      vsync_async = 1; step();
      apb(1, 'h10, 32'h0000_0011, rd, err);
      chk("race_thr", threshold_o[7:0], 8'h55); chk("race_mode", mode_o[1:0], 2'd2);
      apb(0, 'h04, 0, rd, err); chk("race_stat", rd, 32'h3);
      vsync_async = 0; steps(3);
      vsync_async = 1; steps(3);
      chk("race_thr2", threshold_o[7:0], 8'h11);
      apb(0, 'h04, 0, rd, err); chk("race_stat2", rd, 32'h1);

      // W1C landing on frame_start
      vsync_async = 0; steps(3);
      vsync_async = 1; step();
      apb(1, 'h04, 1, rd, err);
      apb(0, 'h04, 0, rd, err); chk("w1c_race", rd, 32'h1);
      apb(1, 'h04, 1, rd, err); chk("w1c_irq_hold", irq, 1);
      step(); chk("w1c_irq_drop", irq, 0);
      apb(0, 'h04, 0, rd, err); chk("w1c_clr", rd, 32'h0);
      apb(0, 'h0C, 0, rd, err); chk("fcnt4", rd, 32'd4);

      // unmapped offset
      apb(1, 'h18, 32'hFFFF_FFFF, rd, err); chk("err_wr", err, 1);
      apb(0, 'h18, 0, rd, err); chk("err_rd", err, 1); chk("err_rdata", rd, 32'h0);
      apb(0, 'h10, 0, rd, err); chk("err_clr", err, 0); chk("err_nochg", rd, 32'h11);

      // reset during the access phase of a write
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = (ADDR_W-2)'('h10 >> 2); PWDATA = 32'h99;
      step();
      PENABLE = 1; PRESETN = 0;
      step();
      PSEL = 0; PENABLE = 0; PRESETN = 1;
      step();
      chk("rst_mid_thr", threshold_o, 16'h4444);
      apb(0, 'h10, 0, rd, err); chk("rst_mid_rb", rd, 32'h44);

      // randomised traffic with free-running vsync
      rand_vs = 1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) step();
         else apb($urandom_range(0, 1) == 1, int'($urandom_range(0, 8)) * 4, $urandom, rd, err);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
